// File: rtl/vpe_act_if.sv
// vpe_act_if: input/output beat bus, sideband and profiling counter of the activation stage
interface vpe_act_if #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int IDX_W = 5,
    parameter int MUX_W = 2,
    parameter int CNT_W = 16
);
    logic [LANES*DW-1:0] i_data;
    logic                i_valid;
    logic                i_ready;
    logic [1:0]          i_mode;
    logic [2:0]          i_shift;
    logic [DW-1:0]       i_clip;
    logic [IDX_W-1:0]    i_rf_idx;
    logic [MUX_W-1:0]    i_rf_mux;
    logic [LANES*DW-1:0] o_data;
    logic                o_valid;
    logic                o_ready;
    logic [IDX_W-1:0]    o_rf_idx;
    logic [MUX_W-1:0]    o_rf_mux;
    logic                i_cnt_clr;
    logic [CNT_W-1:0]    o_neg_cnt;

    modport slave (
        input  i_data, i_valid, i_mode, i_shift, i_clip, i_rf_idx, i_rf_mux, o_ready, i_cnt_clr,
        output i_ready, o_data, o_valid, o_rf_idx, o_rf_mux, o_neg_cnt
    );

    modport master (
        output i_data, i_valid, i_mode, i_shift, i_clip, i_rf_idx, i_rf_mux, o_ready, i_cnt_clr,
        input  i_ready, o_data, o_valid, o_rf_idx, o_rf_mux, o_neg_cnt
    );
endinterface

// File: rtl/vpe_act.sv
// vpe_act: two-stage per-lane activation (bypass/ReLU/leaky/clipped) with backpressure and negative-element counter
module vpe_act #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int IDX_W = 5,
    parameter int MUX_W = 2,
    parameter int CNT_W = 16
) (
    input logic      clk,
    input logic      rst,
    vpe_act_if.slave bus
);
    localparam int NW = $clog2(LANES + 1);
    localparam int SW = CNT_W + NW;

    logic                s1_v, s2_v, s1_adv, s2_adv, in_xfer;
    logic [LANES*DW-1:0] s1_data, act;
    logic [1:0]          s1_mode;
    logic [2:0]          s1_shift;
    logic [DW-1:0]       s1_clip;
    logic [IDX_W-1:0]    s1_idx;
    logic [MUX_W-1:0]    s1_mux;
    logic [NW-1:0]       negs;
    logic [SW-1:0]       sum;

    assign s2_adv      = ~s2_v | bus.o_ready;
    assign s1_adv      = ~s1_v | s2_adv;
    assign bus.i_ready = s1_adv;
    assign bus.o_valid = s2_v;
    assign in_xfer     = bus.i_valid & s1_adv;

    function automatic logic [DW-1:0] act_lane(
        input logic signed [DW-1:0] x,
        input logic [1:0]           mode,
        input logic [2:0]           sh,
        input logic signed [DW-1:0] clip
    );
        logic signed [DW-1:0] c;
        logic signed [DW-1:0] s;
        c = clip[DW-1] ? '0 : clip;
        s = x >>> sh;
        return (x[DW-1] && mode != 2'd0) ? (mode == 2'd2 ? s : '0) : ((mode == 2'd3 && x > c) ? c : x);
    endfunction

    // per-lane activation of the beat held in S1
    always_comb begin
        act = '0;
        for (int k = 0; k < LANES; k++)
            act[k*DW +: DW] = act_lane(s1_data[k*DW +: DW], s1_mode, s1_shift, s1_clip);
    end

    // negative lanes on the input bus and widened counter sum for saturation detect
    always_comb begin
        negs = '0;
        for (int k = 0; k < LANES; k++)
            negs = negs + NW'(bus.i_data[k*DW+DW-1]);
        sum = SW'(bus.o_neg_cnt) + SW'(negs);
    end

    // S1: capture the accepted beat with its per-beat controls and sideband
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
            s1_shift <= '0;
            s1_clip  <= '0;
            s1_idx   <= '0;
            s1_mux   <= '0;
        end else if (s1_adv) begin
            s1_v     <= bus.i_valid;
            s1_data  <= bus.i_data;
            s1_mode  <= bus.i_mode;
            s1_shift <= bus.i_shift;
            s1_clip  <= bus.i_clip;
            s1_idx   <= bus.i_rf_idx;
            s1_mux   <= bus.i_rf_mux;
        end
    end

    // S2: register the activated result and sideband toward the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v         <= 1'b0;
            bus.o_data   <= '0;
            bus.o_rf_idx <= '0;
            bus.o_rf_mux <= '0;
        end else if (s2_adv) begin
            s2_v         <= s1_v;
            bus.o_data   <= act;
            bus.o_rf_idx <= s1_idx;
            bus.o_rf_mux <= s1_mux;
        end
    end

    // saturating negative-element count; clear wins over a same-cycle beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.o_neg_cnt <= '0;
        else if (bus.i_cnt_clr)
            bus.o_neg_cnt <= '0;
        else if (in_xfer && bus.i_mode != 2'd0)
            bus.o_neg_cnt <= (|sum[SW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_vpe_act.sv
// tb_vpe_act: table-driven and sequence checks of the vpe_act activation stage
module tb_vpe_act;
    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int IDX_W = 5;
    localparam int MUX_W = 2;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vpe_act_if #(.LANES(LANES), .DW(DW), .IDX_W(IDX_W), .MUX_W(MUX_W), .CNT_W(CNT_W)) bus();
    vpe_act #(.LANES(LANES), .DW(DW), .IDX_W(IDX_W), .MUX_W(MUX_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  shift;
        logic [7:0]  clip;
        logic [63:0] data;
        logic [63:0] exp;
        int          negs;
    } vec_t;

    vec_t vecs[10];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] relu(input logic [63:0] d);
        logic [63:0] r;
        for (int k = 0; k < 8; k++)
            r[k*8 +: 8] = d[k*8+7] ? 8'h00 : d[k*8 +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [70:0] exp_q[$];
    logic [70:0] hold_val;
    logic        hold_pend, in_x, out_x;
    int          sent, got, occ;

    initial begin
        vecs[0] = '{2'd1, 3'd0, 8'h00, 64'hC040_9001_FF00_807F, 64'h0040_0001_0000_007F, 4};
        vecs[1] = '{2'd2, 3'd2, 8'h00, 64'hFE81_7F00_1080_FFF0, 64'hFFE0_7F00_10E0_FFFC, 5};
        vecs[2] = '{2'd2, 3'd0, 8'h00, 64'hFE81_7F00_1080_FFF0, 64'hFE81_7F00_1080_FFF0, 5};
        vecs[3] = '{2'd2, 3'd7, 8'h00, 64'h0000_0000_C0FF_0180, 64'h0000_0000_FFFF_01FF, 3};
        vecs[4] = '{2'd3, 3'd0, 8'h20, 64'h2100_807F_20F0_1030, 64'h2000_0020_2000_1020, 2};
        vecs[5] = '{2'd3, 3'd0, 8'h90, 64'h2100_807F_20F0_1030, 64'h0000_0000_0000_0000, 2};
        vecs[6] = '{2'd3, 3'd0, 8'h7F, 64'h2100_807F_20F0_1030, 64'h2100_007F_2000_1030, 2};
        vecs[7] = '{2'd0, 3'd5, 8'h10, 64'h8081_FF7F_0102_C3D4, 64'h8081_FF7F_0102_C3D4, 0};
        vecs[8] = '{2'd1, 3'd0, 8'h00, 64'h8080_8080_8080_8080, 64'h0000_0000_0000_0000, 8};
        vecs[9] = '{2'd2, 3'd3, 8'h00, 64'h0102_0304_F8F9_FAFB, 64'h0102_0304_FFFF_FFFF, 4};

        rst = 1'b1;
        bus.i_data = '0; bus.i_valid = 0; bus.i_mode = 0; bus.i_shift = 0; bus.i_clip = 0;
        bus.i_rf_idx = 0; bus.i_rf_mux = 0; bus.o_ready = 1; bus.i_cnt_clr = 0;
        step();
        check("rst_o_valid", 80'(bus.o_valid), 80'd0);
        check("rst_o_data", 80'(bus.o_data), 80'd0);
        check("rst_o_idx_mux", 80'({bus.o_rf_mux, bus.o_rf_idx}), 80'd0);
        check("rst_cnt", 80'(bus.o_neg_cnt), 80'd0);
        rst = 1'b0;
        #1 check("rst_i_ready", 80'(bus.i_ready), 80'd1);
        @(negedge clk);

        // table: one beat per vector, counter cleared beforehand
        for (int i = 0; i < 10; i++) begin
            bus.i_cnt_clr = 1; bus.i_valid = 0;
            step();
            bus.i_cnt_clr = 0;
            bus.i_valid = 1; bus.i_mode = vecs[i].mode; bus.i_shift = vecs[i].shift;
            bus.i_clip = vecs[i].clip; bus.i_data = vecs[i].data;
            bus.i_rf_idx = IDX_W'(i + 3); bus.i_rf_mux = MUX_W'(i);
            step();
            bus.i_valid = 0;
            check($sformatf("v%0d_latency", i), 80'(bus.o_valid), 80'd0);
            check($sformatf("v%0d_cnt", i), 80'(bus.o_neg_cnt), 80'(vecs[i].negs));
            step();
            check($sformatf("v%0d_valid", i), 80'(bus.o_valid), 80'd1);
            check($sformatf("v%0d_data", i), 80'(bus.o_data), 80'(vecs[i].exp));
            check($sformatf("v%0d_side", i), 80'({bus.o_rf_mux, bus.o_rf_idx}),
                  80'({MUX_W'(i), IDX_W'(i + 3)}));
        end

        // counter saturation, clear priority, mode 0 not counted
        bus.i_cnt_clr = 1;
        step();
        bus.i_cnt_clr = 0;
        bus.i_valid = 1; bus.i_mode = 1; bus.i_data = 64'h8080_8080_8080_8080;
        step(); check("cnt_b1", 80'(bus.o_neg_cnt), 80'd8);
        step(); check("cnt_b2_sat", 80'(bus.o_neg_cnt), 80'd15);
        step(); check("cnt_b3_sat", 80'(bus.o_neg_cnt), 80'd15);
        bus.i_cnt_clr = 1;
        step(); check("cnt_clr_prio", 80'(bus.o_neg_cnt), 80'd0);
        bus.i_cnt_clr = 0; bus.i_mode = 0;
        step(); check("cnt_mode0", 80'(bus.o_neg_cnt), 80'd0);
        bus.i_mode = 1; bus.i_data = 64'h0000_0000_0080_FF81;
        step(); check("cnt_after_clr", 80'(bus.o_neg_cnt), 80'd3);
        bus.i_valid = 0;
        step(); step();

        // stream with o_ready pattern 1,0,0,1 and random i_valid against a queue model
        sent = 0; got = 0; occ = 0; hold_pend = 0; hold_val = '0;
        bus.i_mode = 1;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            bus.o_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.i_valid = (sent < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.i_data = {$urandom, $urandom};
            bus.i_rf_idx = IDX_W'(sent + 7);
            bus.i_rf_mux = MUX_W'(sent);
            #1;
            check("stream_i_ready", 80'(bus.i_ready), 80'(!(occ == 2 && !bus.o_ready)));
            if (hold_pend) begin
                check("stream_hold_valid", 80'(bus.o_valid), 80'd1);
                check("stream_hold_data", 80'({bus.o_rf_mux, bus.o_rf_idx, bus.o_data}), 80'(hold_val));
            end
            in_x = bus.i_valid & bus.i_ready;
            out_x = bus.o_valid & bus.o_ready;
            if (out_x) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL stream_spurious: got %h expected no beat", bus.o_data);
                end else
                    check("stream_out", 80'({bus.o_rf_mux, bus.o_rf_idx, bus.o_data}), 80'(exp_q.pop_front()));
                got++;
            end
            hold_pend = bus.o_valid & ~bus.o_ready;
            hold_val = {bus.o_rf_mux, bus.o_rf_idx, bus.o_data};
            if (in_x) begin
                exp_q.push_back({bus.i_rf_mux, bus.i_rf_idx, relu(bus.i_data)});
                sent++;
            end
            occ = occ + int'(in_x) - int'(out_x);
            step();
        end
        check("stream_done", 80'(got), 80'd10);
        bus.i_valid = 0; bus.o_ready = 1;
        step(); step();

        // fill both stages under backpressure; held beats ignore control changes
        bus.o_ready = 0; bus.i_valid = 1; bus.i_mode = 1; bus.i_shift = 0; bus.i_clip = 0;
        bus.i_data = 64'h7F80_0010_FF01_8020; bus.i_rf_idx = 5'h11; bus.i_rf_mux = 2'd1;
        step();
        bus.i_mode = 3; bus.i_clip = 8'h20; bus.i_data = 64'h2100_807F_20F0_1030;
        bus.i_rf_idx = 5'h0C; bus.i_rf_mux = 2'd2;
        step();
        bus.i_mode = 0; bus.i_clip = 8'hFF; bus.i_data = 64'h1111_2222_3333_4444; bus.i_rf_idx = 5'h1F;
        #1 check("full_i_ready", 80'(bus.i_ready), 80'd0);
        for (int j = 0; j < 3; j++) begin
            check("stall_valid", 80'(bus.o_valid), 80'd1);
            check("stall_data", 80'({bus.o_rf_mux, bus.o_rf_idx, bus.o_data}),
                  80'({2'd1, 5'h11, 64'h7F00_0010_0001_0020}));
            step();
        end
        bus.i_valid = 0; bus.o_ready = 1;
        #1 check("ready_recover", 80'(bus.i_ready), 80'd1);
        step();
        bus.o_ready = 0;
        check("held_ctrl_data", 80'({bus.o_rf_mux, bus.o_rf_idx, bus.o_data}),
              80'({2'd2, 5'h0C, 64'h2000_0020_2000_1020}));
        bus.i_valid = 1; bus.i_mode = 1; bus.i_data = 64'h8080_8080_8080_8080;
        step();
        bus.i_valid = 0;
        check("refull_i_ready", 80'(bus.i_ready), 80'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 80'(bus.o_valid), 80'd0);
        check("midrst_data", 80'(bus.o_data), 80'd0);
        check("midrst_cnt", 80'(bus.o_neg_cnt), 80'd0);
        step();
        rst = 1'b0; bus.o_ready = 1;
        #1 check("postrst_i_ready", 80'(bus.i_ready), 80'd1);
        for (int j = 0; j < 4; j++) begin
            step();
            check("postrst_no_beat", 80'(bus.o_valid), 80'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
